// File: rtl/prio_encoder_rr_if.sv
// rtl/prio_encoder_rr_if.sv - request/grant handshake bundle for prio_encoder_rr
// Optional multi flag present when PRIO_ENC_MULTI_FLAG_EN is defined.
interface prio_encoder_rr_if #(
  parameter int N = 8,
  parameter int W = 3
);
  logic         enable;
  logic [N-1:0] d;
  logic         mode;
  logic         out_ready;
  logic [W-1:0] y;
  logic [N-1:0] grant;
  logic         out_valid;
`ifdef PRIO_ENC_MULTI_FLAG_EN
  logic         multi;

  modport master (
    output enable, d, mode, out_ready,
    input  y, grant, out_valid, multi
  );

  modport slave (
    input  enable, d, mode, out_ready,
    output y, grant, out_valid, multi
  );
`else
  modport master (
    output enable, d, mode, out_ready,
    input  y, grant, out_valid
  );

  modport slave (
    input  enable, d, mode, out_ready,
    output y, grant, out_valid
  );
`endif
endinterface

// File: rtl/prio_encoder_rr.sv
// rtl/prio_encoder_rr.sv - registered N-to-log2(N) priority encoder, fixed or round-robin
// Optional multi-request flag enabled by PRIO_ENC_MULTI_FLAG_EN.
module prio_encoder_rr #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  prio_encoder_rr_if.slave bus
);

  if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_n
    $error("prio_encoder_rr: N must be a power of two >= 2");
  end
  if (W != $clog2(N)) begin : g_bad_w
    $error("prio_encoder_rr: W must equal log2(N)");
  end

  logic [W-1:0] y_q, y_d;
  logic [N-1:0] grant_q, grant_d;
  logic         valid_q, valid_d;
  logic [W-1:0] lg_q, lg_d;
  logic [W-1:0] fix_idx, rr_idx, win_idx;
  logic         cap;

  always_comb begin
    fix_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.d[i]) fix_idx = W'(i);
    end
  end

  // Walk from the farthest scan slot to the nearest so the nearest set bit
  // (lg-1 first, lg itself last) is the one left standing.
  always_comb begin
    logic [W-1:0] scan;
    rr_idx = '0;
    scan   = '0;
    for (int k = N; k >= 1; k--) begin
      scan = lg_q - W'(k);
      if (bus.d[scan]) rr_idx = scan;
    end
  end

  assign win_idx = bus.mode ? rr_idx : fix_idx;
  assign cap     = bus.enable & (|bus.d) & (~valid_q | bus.out_ready);

  always_comb begin
    y_d     = y_q;
    grant_d = grant_q;
    valid_d = valid_q;
    lg_d    = lg_q;
    if (cap) begin
      y_d          = win_idx;
      grant_d      = '0;
      grant_d[win_idx] = 1'b1;
      valid_d      = 1'b1;
      if (bus.mode) lg_d = win_idx;
    end else if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q     <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
      lg_q    <= '0;
    end else begin
      y_q     <= y_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      lg_q    <= lg_d;
    end
  end

  assign bus.y         = y_q;
  assign bus.grant     = grant_q;
  assign bus.out_valid = valid_q;

`ifdef PRIO_ENC_MULTI_FLAG_EN
  logic multi_q, multi_d;

  always_comb begin
    multi_d = multi_q;
    if (cap) multi_d = (bus.d & (bus.d - N'(1))) != '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) multi_q <= 1'b0;
    else        multi_q <= multi_d;
  end

  assign bus.multi = multi_q;
`endif

endmodule

// File: tb/tb_prio_encoder_rr.sv
// tb/tb_prio_encoder_rr.sv - randomized and directed bench for prio_encoder_rr
// Optional multi flag checked when PRIO_ENC_MULTI_FLAG_EN is defined.
module tb_prio_encoder_rr;
  localparam int N = 8;
  localparam int W = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  // reference state
  int   m_y, m_lg;
  logic [N-1:0] m_grant;
  bit   m_valid, m_multi;

  prio_encoder_rr_if #(.N(N), .W(W)) bus ();

  prio_encoder_rr #(.N(N), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Build the full scan order as a list, then take the first requester in it.
  function automatic int model_win(logic [N-1:0] dv, bit rr, int lg);
    int order[$];
    if (!rr) begin
      for (int i = N - 1; i >= 0; i--) order.push_back(i);
    end else begin
      for (int s = 1; s <= N; s++) order.push_back((lg - s + N) % N);
    end
    foreach (order[j]) if (dv[order[j]]) return order[j];
    return -1;
  endfunction

  task automatic model_step();
    bit cap;
    int w;
    cap = bus.enable && (bus.d != 0) && (!m_valid || bus.out_ready);
    if (!rst_n) begin
      m_y = 0; m_grant = '0; m_valid = 0; m_lg = 0; m_multi = 0;
    end else if (cap) begin
      w       = model_win(bus.d, bus.mode, m_lg);
      m_y     = w;
      m_grant = N'(1) << w;
      m_valid = 1;
      m_multi = $countones(bus.d) > 1;
      if (bus.mode) m_lg = w;
    end else if (m_valid && bus.out_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check({tag, "_valid"}, 32'(bus.out_valid), 32'(m_valid));
    check({tag, "_y"},     32'(bus.y),         32'(m_y));
    check({tag, "_grant"}, 32'(bus.grant),     32'(m_grant));
`ifdef PRIO_ENC_MULTI_FLAG_EN
    check({tag, "_multi"}, 32'(bus.multi),     32'(m_multi));
`endif
  endtask

  task automatic drive(input logic en, input logic [N-1:0] dv, input logic md, input logic rdy);
    bus.enable = en; bus.d = dv; bus.mode = md; bus.out_ready = rdy;
  endtask

  initial begin
    int rot_exp[9];
    int sp_exp[4];
    rot_exp = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
    sp_exp  = '{5, 2, 5, 2};
    m_y = 0; m_lg = 0; m_grant = '0; m_valid = 0; m_multi = 0;
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b1);

    // reset, fixed mode
    tick("rst0");
    tick("rst1");
    check("rst_valid_const", 32'(bus.out_valid), 0);
    check("rst_y_const", 32'(bus.y), 0);
    rst_n = 1'b1;
    drive(1'b1, 8'b00001000, 1'b0, 1'b1); tick("fix_a"); check("fix_y3", 32'(bus.y), 3);
    drive(1'b1, 8'b10000000, 1'b0, 1'b1); tick("fix_b"); check("fix_y7", 32'(bus.y), 7);
    drive(1'b1, 8'b01001000, 1'b0, 1'b1); tick("fix_c"); check("fix_y6", 32'(bus.y), 6);
    check("fix_grant6", 32'(bus.grant), 32'h40);

    // round-robin rotation from reset
    rst_n = 1'b0; tick("rr_rst"); rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 8'hFF, 1'b1, 1'b1); tick("rot");
      check("rot_seq", 32'(bus.y), 32'(rot_exp[i]));
    end

    // sparse round-robin, then single requester
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'b00100100, 1'b1, 1'b1); tick("sparse");
      check("sparse_seq", 32'(bus.y), 32'(sp_exp[i]));
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'b00000010, 1'b1, 1'b1); tick("single");
      check("single_y1", 32'(bus.y), 1);
    end

    // backpressure
    drive(1'b1, 8'b00010000, 1'b0, 1'b1); tick("bp_cap"); check("bp_y4", 32'(bus.y), 4);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'b10000000, 1'b0, 1'b0); tick("bp_hold");
      check("bp_hold_y4", 32'(bus.y), 4);
      check("bp_hold_valid", 32'(bus.out_valid), 1);
    end
    drive(1'b1, 8'b10000000, 1'b0, 1'b1); tick("bp_rel"); check("bp_rel_y7", 32'(bus.y), 7);

    // enable low, idle, mid-operation reset
    drive(1'b0, 8'b00000001, 1'b0, 1'b1); tick("en0_a"); check("en0_drop", 32'(bus.out_valid), 0);
    tick("en0_b");
    drive(1'b1, 8'b00000000, 1'b0, 1'b1); tick("idle"); check("idle_valid", 32'(bus.out_valid), 0);
    drive(1'b1, 8'b00000100, 1'b1, 1'b0); tick("pre_rst"); check("pre_rst_valid", 32'(bus.out_valid), 1);
    rst_n = 1'b0; tick("mid_rst");
    check("mid_rst_valid", 32'(bus.out_valid), 0);
    check("mid_rst_grant", 32'(bus.grant), 0);
    rst_n = 1'b1;
    drive(1'b1, 8'hFF, 1'b1, 1'b1); tick("post_rst"); check("post_rst_y7", 32'(bus.y), 7);

`ifdef PRIO_ENC_MULTI_FLAG_EN
    drive(1'b1, 8'b01001000, 1'b0, 1'b1); tick("mf_a"); check("multi_1", 32'(bus.multi), 1);
    drive(1'b1, 8'b00000010, 1'b0, 1'b0); tick("mf_h"); check("multi_hold", 32'(bus.multi), 1);
    drive(1'b1, 8'b00000010, 1'b0, 1'b1); tick("mf_b"); check("multi_0", 32'(bus.multi), 0);
`endif

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] dv;
      dv = N'($urandom);
      if ($urandom_range(3) == 0) dv = dv & N'($urandom);
      if ($urandom_range(7) == 0) dv = '0;
      rst_n = ($urandom_range(59) != 0);
      drive(($urandom_range(5) != 0), dv, 1'($urandom), ($urandom_range(3) != 0));
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/prio_encoder_rr.md
Name: prio_encoder_rr

Overview:
- Parametrised, registered N-to-log2(N) priority encoder; successor to the fixed 8-to-3 combinational encoder.
- Supports two priority modes: fixed (highest index wins) and round-robin (rotating priority).
- Adds a valid/ready output handshake. A captured code is held until the consumer accepts it.
- Sits between request sources (interrupt lines, channel requests) and a single downstream consumer.

Parameters:
- N, 8, number of request inputs; must be ≥ 2 and a power of two.
- W, 3, encoded output width; must equal log2(N). An elaboration check fails if it does not.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, synchronous active-low reset.
- enable, input, 1, capture enable; when 0, no new request is captured.
- d, input, N, request vector; bit i is request i.
- mode, input, 1, priority mode: 0 = fixed, 1 = round-robin.
- out_ready, input, 1, consumer accepts the held code this cycle.
- y, output, W, encoded index of the granted request.
- grant, output, N, one-hot copy of the granted request.
- out_valid, output, 1, y and grant hold a code not yet accepted.

Behaviour:
- Reset: synchronous, sampled on the rising clk edge while rst_n=0.
  - Reset values: y=0, grant=0, out_valid=0, internal last_grant pointer lg=0.
  - Reset overrides all other activity, including a pending handshake. A held code is discarded.
- Capture condition, evaluated each clock: cap = enable & (d != 0) & (!out_valid | out_ready).
- On cap, at the next edge:
  - y = winning index, grant = one-hot of the winner, out_valid = 1.
  - Latency is 1 clock from d to y.
- Accept without capture: if out_valid & out_ready & !cap, then out_valid is cleared next edge. y and grant keep their last values.
- Hold: if out_valid & !out_ready, then y, grant and out_valid are frozen. d changes are ignored.
- Back-to-back: if out_valid & out_ready & cap, the new code replaces the old one in the same edge and out_valid stays 1. This gives one code per clock of throughput.
- Fixed mode (mode=0): the highest set index wins. Example: d=8'b01001000 gives y=6. lg is not updated.
- Round-robin mode (mode=1):
  - Scan order is lg-1, lg-2, …, 0, N-1, …, lg, wrapping modulo N. The first set bit wins.
  - On capture, lg is set to the winning index.
  - After reset (lg=0) the scan starts at N-1, so the first grant matches fixed mode.
  - A single requester is granted repeatedly.
- Mode changes take effect at the next capture. lg is retained across mode switches.
- d=0 with enable=1: no capture. out_valid follows the accept rules above.
- enable=0: no capture. A pending code still completes its handshake normally.
- Exactly one grant bit is set whenever out_valid=1. grant is 0 only after reset.

Optional Feature:
- Macro: PRIO_ENC_MULTI_FLAG_EN.
- When defined:
  - Adds output port multi (1 bit), registered alongside y.
  - multi=1 when the captured d had more than one bit set, otherwise 0.
  - Reset value 0. multi is held and updated under exactly the same rules as y.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan (N=8):
- Reset, fixed mode:
  - Stimulus: assert rst_n=0 for 2 clocks, then enable=1, mode=0, out_ready=1, apply d=8'b00001000, 8'b10000000, 8'b01001000 on successive clocks.
  - Expected: out_valid=0 and y=0 during reset; then y=3, 7, 6, each one clock after its d, with grant one-hot matching y.
- Round-robin rotation:
  - Stimulus: mode=1, out_ready=1, d=8'hFF held for 9 clocks after reset.
  - Expected: y sequence 7,6,5,4,3,2,1,0,7.
- Round-robin sparse requests:
  - Stimulus: mode=1, d=8'b00100100.
  - Expected: y alternates 5,2,5,2; single request d=8'b00000010 then gives y=1 every clock.
- Backpressure:
  - Stimulus: capture d=8'b00010000 (y=4), then out_ready=0 for 3 clocks while d=8'b10000000.
  - Expected: y=4 and out_valid=1 held for all 3 clocks; when out_ready=1, y=7 on the next edge.
- Enable, idle and mid-operation reset:
  - Stimulus: enable=0 with d=8'b00000001, out_ready=1; then d=0 with enable=1; then rst_n=0 while out_valid=1 and out_ready=0.
  - Expected: no capture while enable=0, so out_valid falls after the accept; no capture for d=0; on reset, out_valid=0, y=0, grant=0 next edge, and a subsequent RR scan starts at index 7.
- PRIO_ENC_MULTI_FLAG_EN:
  - Stimulus: d=8'b01001000, then d=8'b00000010.
  - Expected: multi=1, then multi=0; multi is held under backpressure exactly like y.
